conv_seq_ctrl: RTL

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// Convolution pass sequencer: steps N taps per window, drains the MAC pipeline,
// hands each result to the sink, W windows per pass. CONV_SEQ_DIM_CHECK_EN adds cfg_err.
module conv_seq_ctrl #(
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned OUT_AW  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [8:0]        SI_Height_W,
  input  logic [8:0]        SI_Weight_W,
  input  logic [8:0]        LI_Height_W,
  input  logic [8:0]        LI_Weight_W,
  input  logic              out_ready,
  output logic              addr_en,
  output logic [9:0]        count,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              done
`ifdef CONV_SEQ_DIM_CHECK_EN
  ,
  output logic              cfg_err
`endif
);

  localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_e;

  state_e              state_q, state_d;
  logic [8:0]          si_h_q, si_h_d, si_w_q, si_w_d;
  logic [8:0]          li_h_q, li_h_d, li_w_q, li_w_d;
  logic [9:0]          count_q, count_d;
  logic [OUT_AW-1:0]   oaddr_q, oaddr_d;
  logic [19:0]         win_q, win_d;
  logic [DW-1:0]       drn_q, drn_d;
  logic [MAC_LAT-1:0]  dl_q;
  logic [MAC_LAT:0]    dl_ext;

  logic [17:0]         n_taps;
  logic [9:0]          win_x, win_y;
  logic [19:0]         n_wins;
  logic                last_tap, last_win, drain_last, accept;

  assign n_taps     = {9'd0, si_h_q} * {9'd0, si_w_q};
  assign win_x      = {1'b0, li_w_q} - {1'b0, si_w_q} + 10'd1;
  assign win_y      = {1'b0, li_h_q} - {1'b0, si_h_q} + 10'd1;
  assign n_wins     = {10'd0, win_x} * {10'd0, win_y};
  assign last_tap   = ({8'd0, count_q} == (n_taps - 18'd1));
  assign last_win   = (win_q == (n_wins - 20'd1));
  assign drain_last = (drn_q == DW'(MAC_LAT - 1));

`ifdef CONV_SEQ_DIM_CHECK_EN
  logic        cfg_err_q, cfg_err_d, dims_bad;
  logic [17:0] in_taps;

  assign in_taps  = {9'd0, SI_Height_W} * {9'd0, SI_Weight_W};
  assign dims_bad = (SI_Height_W == '0) || (SI_Weight_W == '0) ||
                    (LI_Height_W == '0) || (LI_Weight_W == '0) ||
                    (SI_Weight_W > LI_Weight_W) || (SI_Height_W > LI_Height_W) ||
                    (in_taps > 18'd1024);
  assign accept    = start && !dims_bad;
  assign cfg_err_d = (state_q == IDLE) && start && dims_bad;
  assign cfg_err   = cfg_err_q;
`else
  assign accept = start;
`endif

  always_comb begin
    state_d   = state_q;
    si_h_d    = si_h_q;
    si_w_d    = si_w_q;
    li_h_d    = li_h_q;
    li_w_d    = li_w_q;
    count_d   = count_q;
    oaddr_d   = oaddr_q;
    win_d     = win_q;
    drn_d     = drn_q;
    addr_en   = 1'b0;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          si_h_d  = SI_Height_W;
          si_w_d  = SI_Weight_W;
          li_h_d  = LI_Height_W;
          li_w_d  = LI_Weight_W;
          count_d = '0;
          oaddr_d = '0;
          win_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        addr_en = 1'b1;
        acc_clr = (count_q == '0);
        if (last_tap) begin
          count_d = '0;
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          count_d = count_q + 10'd1;
        end
      end
      DRAIN: begin
        if (drain_last) state_d = WRITE;
        else            drn_d   = drn_q + DW'(1);
      end
      WRITE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_win) begin
            state_d = FIN;
          end else begin
            oaddr_d = oaddr_q + OUT_AW'(1);
            win_d   = win_q + 20'd1;
            state_d = RUN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // acc_en is addr_en seen MAC_LAT edges later; bit 0 holds the newest sample
  assign dl_ext = {dl_q, addr_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      si_h_q  <= '0;
      si_w_q  <= '0;
      li_h_q  <= '0;
      li_w_q  <= '0;
      count_q <= '0;
      oaddr_q <= '0;
      win_q   <= '0;
      drn_q   <= '0;
      dl_q    <= '0;
`ifdef CONV_SEQ_DIM_CHECK_EN
      cfg_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      si_h_q  <= si_h_d;
      si_w_q  <= si_w_d;
      li_h_q  <= li_h_d;
      li_w_q  <= li_w_d;
      count_q <= count_d;
      oaddr_q <= oaddr_d;
      win_q   <= win_d;
      drn_q   <= drn_d;
      dl_q    <= dl_ext[MAC_LAT-1:0];
`ifdef CONV_SEQ_DIM_CHECK_EN
      cfg_err_q <= cfg_err_d;
`endif
    end
  end

  assign acc_en   = dl_q[MAC_LAT-1];
  assign count    = count_q;
  assign out_addr = oaddr_q;
  assign busy     = (state_q != IDLE);

endmodule
